// File: rtl/sv_bus_responder.sv
// Addr/data/wen/ren/ready bus target backed by a DEPTH-entry register file with programmable wait states.
// Optional SV_RESP_PARITY_EN adds the rparity output and a parity check on write data.
module sv_bus_responder #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 64,
    parameter int                TAG_W       = 3,
    parameter int                DEPTH       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [TAG_W-1:0]  valid,
    input  logic [DATA_W-1:0] data,
    input  logic              wen,
    input  logic              ren,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic [TAG_W-1:0]  rtag,
    output logic              err
`ifdef SV_RESP_PARITY_EN
    ,
    output logic              rparity
`endif
);

    localparam int                OFF_BITS = $clog2(DATA_W / 8);
    localparam int                IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_BITS) - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [7:0]        CNT_LOAD = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t            state, state_next;
    logic [7:0]        cnt;
    logic              req;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [TAG_W-1:0]  lat_tag;
    logic              lat_wen, lat_ren;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] off, idx_full;
    logic [IDX_W-1:0]  idx;
    logic              misaligned, oob, parity_bad, bad, commit;
    logic              resp;
    logic [DATA_W-1:0] rdata_next;
    logic              err_next;

    assign req = wen | ren;

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req) state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (cnt == 8'd0) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture; the bus is only sampled in IDLE, the latched copy drives everything after.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_tag  <= '0;
            lat_wen  <= 1'b0;
            lat_ren  <= 1'b0;
        end else if (state == ST_IDLE && req) begin
            cnt      <= CNT_LOAD;
            lat_addr <= addr;
            lat_data <= data;
            lat_tag  <= valid;
            lat_wen  <= wen;
            lat_ren  <= ren;
        end else if (state == ST_WAIT && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    always_comb begin
        off        = lat_addr - BASE_ADDR;
        idx_full   = off >> OFF_BITS;
        idx        = idx_full[IDX_W-1:0];
        misaligned = (off & OFF_MASK) != '0;
        oob        = idx_full >= DEPTH_A;
`ifdef SV_RESP_PARITY_EN
        parity_bad = lat_wen & (^lat_data);
`else
        parity_bad = 1'b0;
`endif
        bad        = (lat_wen & lat_ren) | misaligned | oob | parity_bad;
        commit     = (state == ST_RESP) & lat_wen & ~bad;
    end

    always_comb begin
        resp       = (state == ST_RESP);
        err_next   = bad;
        rdata_next = '0;
        if (resp && lat_ren && !bad) rdata_next = mem[idx];
    end

    // Outputs are registered, so ready appears in the cycle after RESP and the write commits on that same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ready   <= 1'b0;
            rdata   <= '0;
            rtag    <= '0;
            err     <= 1'b0;
`ifdef SV_RESP_PARITY_EN
            rparity <= 1'b0;
`endif
        end else begin
            ready <= resp;
            if (resp) begin
                rdata   <= rdata_next;
                rtag    <= lat_tag;
                err     <= err_next;
`ifdef SV_RESP_PARITY_EN
                rparity <= ^rdata_next;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit) begin
            mem[idx] <= lat_data;
        end
    end

endmodule

// File: tb/tb_sv_bus_responder.sv
// Directed bench for sv_bus_responder: one instance with two wait states, one with none.
// Honours SV_RESP_PARITY_EN for the rparity port and parity-error cases.
module tb_sv_bus_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] addr, z_addr;
    logic [2:0]  valid, z_valid;
    logic [63:0] data, z_data;
    logic        wen, ren, z_wen, z_ren;
    logic        ready, z_ready;
    logic [63:0] rdata, z_rdata;
    logic [2:0]  rtag, z_rtag;
    logic        err, z_err;
`ifdef SV_RESP_PARITY_EN
    logic        rparity, z_rparity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] PAT = 64'hDEADBEEF_01234567;

    sv_bus_responder #(.ADDR_W(32), .DATA_W(64), .TAG_W(3), .DEPTH(16),
                       .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .addr(addr), .valid(valid), .data(data),
        .wen(wen), .ren(ren), .ready(ready), .rdata(rdata), .rtag(rtag), .err(err)
`ifdef SV_RESP_PARITY_EN
        , .rparity(rparity)
`endif
    );

    sv_bus_responder #(.ADDR_W(32), .DATA_W(64), .TAG_W(3), .DEPTH(16),
                       .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .addr(z_addr), .valid(z_valid), .data(z_data),
        .wen(z_wen), .ren(z_ren), .ready(z_ready), .rdata(z_rdata), .rtag(z_rtag), .err(z_err)
`ifdef SV_RESP_PARITY_EN
        , .rparity(z_rparity)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wen = 1'b0; ren = 1'b0; z_wen = 1'b0; z_ren = 1'b0;
        @(negedge clk);
    endtask

    // Drives one request (sel=1 targets the zero-wait instance) and checks the response.
    // Returns in the ready cycle with the request still driven, so a caller can chain back-to-back.
    task automatic run(input bit sel, input logic w, input logic r, input logic [31:0] a,
                       input logic [63:0] d, input logic [2:0] t,
                       input logic [63:0] exp_rd, input logic exp_err, input string name);
        int   lat;
        logic seen;
        if (sel) begin z_addr = a; z_data = d; z_valid = t; z_wen = w; z_ren = r; end
        else     begin addr = a;   data = d;   valid = t;   wen = w;   ren = r;   end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = sel ? z_ready : ready;
        end
        check($sformatf("%s.lat", name), 64'(lat), sel ? 64'd2 : 64'd4);
        check($sformatf("%s.rdata", name), sel ? z_rdata : rdata, exp_rd);
        check($sformatf("%s.err", name), 64'(sel ? z_err : err), 64'(exp_err));
        check($sformatf("%s.rtag", name), 64'(sel ? z_rtag : rtag), 64'(t));
`ifdef SV_RESP_PARITY_EN
        check($sformatf("%s.par", name), 64'(sel ? z_rparity : rparity), 64'(^exp_rd));
`endif
    endtask

    initial begin
        int hits;
        reset = 1'b0;
        addr = '0; data = '1; valid = 3'd7; wen = 1'b1; ren = 1'b0;
        z_addr = '0; z_data = '1; z_valid = 3'd7; z_wen = 1'b1; z_ren = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check("rst.ready", 64'(ready), 64'd0);
            check("rst.rdata", rdata, 64'd0);
            check("rst.rtag", 64'(rtag), 64'd0);
            check("rst.err", 64'(err), 64'd0);
        end
        reset = 1'b1;
        wen = 1'b0; z_wen = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run(0, 1'b0, 1'b1, 32'(i * 8), 64'd0, 3'(i), 64'd0, 1'b0, "rst_rd");
            idle();
        end

        run(0, 1'b1, 1'b0, 32'h08, PAT, 3'd5, 64'd0, 1'b0, "wr");
        idle();
        run(0, 1'b0, 1'b1, 32'h08, 64'd0, 3'd2, PAT, 1'b0, "rd");
        idle();

        run(0, 1'b1, 1'b0, 32'h80, 64'h11, 3'd1, 64'd0, 1'b1, "oob_wr");
        idle();
        run(0, 1'b1, 1'b0, 32'h0C, 64'h22, 3'd2, 64'd0, 1'b1, "misal_wr");
        idle();
        run(0, 1'b1, 1'b1, 32'h08, 64'h33, 3'd3, 64'd0, 1'b1, "wen_ren");
        idle();
        run(0, 1'b0, 1'b1, 32'h0C, 64'd0, 3'd4, 64'd0, 1'b1, "misal_rd");
        idle();
        run(0, 1'b0, 1'b1, 32'h80, 64'd0, 3'd5, 64'd0, 1'b1, "oob_rd");
        idle();
        run(0, 1'b0, 1'b1, 32'h08, 64'd0, 3'd6, PAT, 1'b0, "rd_keep");
        idle();
        run(0, 1'b0, 1'b1, 32'h00, 64'd0, 3'd7, 64'd0, 1'b0, "rd_idx0");
        idle();
`ifdef SV_RESP_PARITY_EN
        run(0, 1'b1, 1'b0, 32'h10, 64'h01, 3'd1, 64'd0, 1'b1, "par_err");
        idle();
        run(0, 1'b0, 1'b1, 32'h10, 64'd0, 3'd2, 64'd0, 1'b0, "par_keep");
        idle();
`endif

        run(0, 1'b1, 1'b0, 32'h78, 64'hA5, 3'd7, 64'd0, 1'b0, "wr15");
        idle();
        run(0, 1'b0, 1'b1, 32'h08, 64'd0, 3'd1, PAT, 1'b0, "b2b0");
        run(0, 1'b0, 1'b1, 32'h78, 64'd0, 3'd2, 64'hA5, 1'b0, "b2b1");
        run(0, 1'b0, 1'b1, 32'h00, 64'd0, 3'd3, 64'd0, 1'b0, "b2b2");
        run(0, 1'b0, 1'b1, 32'h08, 64'd0, 3'd4, PAT, 1'b0, "b2b3");
        idle();
        check("b2b.width", 64'(ready), 64'd0);

        addr = 32'h10; data = 64'h55; valid = 3'd6; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
        reset = 1'b0;
        hits = 0;
        repeat (2) begin @(negedge clk); hits += int'(ready); end
        reset = 1'b1;
        repeat (6) begin @(negedge clk); hits += int'(ready); end
        check("abort.ready", 64'(hits), 64'd0);
        check("abort.rtag", 64'(rtag), 64'd0);
        run(0, 1'b0, 1'b1, 32'h10, 64'd0, 3'd3, 64'd0, 1'b0, "abort_rd");
        idle();

        run(1, 1'b1, 1'b0, 32'h18, 64'h0F, 3'd3, 64'd0, 1'b0, "z_wr");
        idle();
        run(1, 1'b0, 1'b1, 32'h18, 64'd0, 3'd7, 64'h0F, 1'b0, "z_rd");
        idle();
        run(1, 1'b0, 1'b1, 32'h88, 64'd0, 3'd2, 64'd0, 1'b1, "z_oob");
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
